// File: rtl/lsu_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundles the load/store request/response handshake and the word-wide data
// memory bus used by lsu_mem_ctrl.
//   req_*      : request from the memory stage (valid/ready handshake)
//   resp_*     : one-cycle completion pulse with load data and error flag
//   MemRead/MemWrite/addr/WriteData : strobes and data towards the memory
//   ReadData   : combinational read data from the memory
// Modports:
//   slave  - the load/store controller
//   master - the environment (core memory stage plus the data memory)
// ----------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ReadData,
    output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, addr, WriteData
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ReadData,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, addr, WriteData
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store initiator between the core memory stage and a word-wide data
// memory. Byte/half/word loads are sign- or zero-extended; byte/half stores
// are performed as read-modify-write so the memory only sees full-word writes.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (aborts any operation in flight)
//   bus   - lsu_mem_ctrl_if.slave: request/response handshake and memory bus
// Parameters:
//   ADDR_W    - address width
//   MEM_BYTES - decoded memory size; accesses reaching past it are errors
// Build option:
//   LSU_ALIGN_TRAP_EN - when defined, misaligned half/word requests return an
//                       error; otherwise they are silently forced aligned.
// All outputs are registered and follow the FSM state they belong to.
// ----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;

  // Registered outputs
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       write_data_q, write_data_d;

  // Request decode
  logic [ADDR_W-1:0] ea_s;
  logic              misalign_s;
  logic              req_err_s;

  // True when the last byte touched lies at or beyond MEM_BYTES.
  function automatic logic range_err(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic [ADDR_W:0] last;
    case (sz)
      2'b00:   last = {1'b0, a};
      2'b01:   last = {1'b0, a} + (ADDR_W+1)'(1);
      2'b10:   last = {1'b0, a} + (ADDR_W+1)'(3);
      default: last = {1'b0, a};
    endcase
    return (last >= (ADDR_W+1)'(MEM_BYTES));
  endfunction

  // Select the addressed byte/half from a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] lane);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half lane of the old word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (sz)
      2'b00: begin
        mask = 32'h000000FF << {lane, 3'b000};
        data = {24'h000000, wd[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        mask = lane[1] ? 32'hFFFF0000 : 32'h0000FFFF;
        data = lane[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
      end
      default: begin
        mask = 32'hFFFFFFFF;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  // Effective address (alignment forced) and error classification of the incoming request.
  always_comb begin
    ea_s       = bus.req_addr;
    misalign_s = 1'b0;
    case (bus.req_size)
      2'b01:   ea_s = {bus.req_addr[ADDR_W-1:1], 1'b0};
      2'b10:   ea_s = {bus.req_addr[ADDR_W-1:2], 2'b00};
      default: ea_s = bus.req_addr;
    endcase
`ifdef LSU_ALIGN_TRAP_EN
    misalign_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    req_err_s = (bus.req_size == 2'b11) || misalign_s ||
                range_err(bus.req_addr, bus.req_size);
  end

  // Next-state and next-output logic; outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    addr_d       = addr_q;
    write_data_d = write_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          lane_d  = ea_s[1:0];
          wdata_d = bus.req_wdata;
          if (req_err_s) begin
            state_d      = S_DONE;
            resp_rdata_d = 32'h00000000;
            resp_err_d   = 1'b1;
          end else begin
            addr_d = {ea_s[ADDR_W-1:2], 2'b00};
            if (bus.req_we && (bus.req_size == 2'b10)) begin
              state_d      = S_WR;
              write_data_d = bus.req_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        // ReadData is combinational and valid now; consume it at this edge.
        if (we_q) begin
          state_d      = S_WR;
          write_data_d = store_merge(bus.ReadData, wdata_q, size_q, lane_q);
        end else begin
          state_d      = S_DONE;
          resp_rdata_d = load_extract(bus.ReadData, size_q, uns_q, lane_q);
          resp_err_d   = 1'b0;
        end
      end
      S_WR: begin
        state_d      = S_DONE;
        resp_rdata_d = 32'h00000000;
        resp_err_d   = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    mem_read_d   = (state_d == S_RD);
    mem_write_d  = (state_d == S_WR);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h00000000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h00000000;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      write_data_q <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.addr       = addr_q;
  assign bus.WriteData  = write_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Directed self-checking bench for lsu_mem_ctrl with a 256-word memory model.
// ----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Data memory model: combinational read, synchronous full-word write.
  logic [31:0] mem [0:255];
  assign bus.ReadData = bus.MemRead ? mem[bus.addr[9:2]] : 32'h00000000;
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.addr[9:2]] <= bus.WriteData;
  end

  // Issue one request and observe it until resp_valid (or a bounded timeout).
  // lat counts clock edges from the accept edge (inclusive) to the edge that raised resp_valid.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output int nrd, output int nwr, output logic [31:0] wlast,
                        output logic [31:0] maddr);
    int w;
    rd = 32'h0; err = 1'b0; lat = -1; nrd = 0; nwr = 0; wlast = 32'h0; maddr = 32'h0; w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.MemRead)  begin nrd++; maddr = bus.addr; end
      if (bus.MemWrite) begin nwr++; wlast = bus.WriteData; maddr = bus.addr; end
      if (bus.resp_valid) begin
        lat = k; rd = bus.resp_rdata; err = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite});
    end
    n_cmp++;
    if ({bus.addr, bus.WriteData, bus.resp_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wd=%h rdata=%h want all 0", bus.addr, bus.WriteData, bus.resp_rdata);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, wl, ma; logic err; int lat, nrd, nwr;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if ({lat, nrd, nwr} !== {32'd2, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL sw_timing: lat=%0d rd=%0d wr=%0d want 2/0/1", lat, nrd, nwr);
    end
    n_cmp++;
    if ({wl, ma, err, rd} !== {32'hDEADBEEF, 32'h10, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL sw_data: wd=%h addr=%h err=%b rdata=%h want deadbeef/10/0/0", wl, ma, err, rd);
    end
    n_cmp++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if ({lat, nrd, nwr, err} !== {32'd2, 32'd1, 32'd0, 1'b0} || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw: lat=%0d rd=%0d wr=%0d err=%b data=%h want 2/1/0/0/deadbeef",
                         lat, nrd, nwr, err, rd);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd, wl, ma; logic err; int lat, nrd, nwr;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if ({lat, nrd, nwr} !== {32'd3, 32'd1, 32'd1} || wl !== 32'hDEAABEEF || ma !== 32'h10) begin
      n_fail++; $display("FAIL sb: lat=%0d rd=%0d wr=%0d wd=%h addr=%h want 3/1/1/deaabeef/10",
                         lat, nrd, nwr, wl, ma);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h00000000, rd, err, lat, nrd, nwr, wl, ma);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (lat !== 3 || wl !== 32'h12340000) begin
      n_fail++; $display("FAIL sh: lat=%0d wd=%h want 3/12340000", lat, wl);
    end
    do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (rd !== 32'h00001234) begin
      n_fail++; $display("FAIL lhu_upper: got %h want 00001234", rd);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] rd, wl, ma; logic err; int lat, nrd, nwr;
    logic [1:0]  szv [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        unv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exv [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDEAA, 32'h0000DEAA};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szv[i], unv[i], 32'h12, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
      n_cmp++;
      if (rd !== exv[i] || lat !== 2 || err !== 1'b0) begin
        n_fail++; $display("FAIL load_ext[%0d]: data=%h lat=%0d err=%b want %h/2/0", i, rd, lat, err, exv[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wl, ma; logic err; int lat, nrd, nwr;
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5A5A5, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (err !== 1'b0 || lat !== 2 || mem[255] !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL sw_last_word: err=%b lat=%0d mem=%h want 0/2/a5a5a5a5", err, lat, mem[255]);
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (err !== 1'b0 || rd !== 32'hFFFFFFA5) begin
      n_fail++; $display("FAIL lb_last_byte: err=%b data=%h want 0/ffffffa5", err, rd);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || (nrd + nwr) !== 0) begin
      n_fail++; $display("FAIL lh_past_end: err=%b data=%h lat=%0d strobes=%0d want 1/0/1/0", err, rd, lat, nrd + nwr);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || (nrd + nwr) !== 0) begin
      n_fail++; $display("FAIL lw_0x400: err=%b data=%h lat=%0d strobes=%0d want 1/0/1/0", err, rd, lat, nrd + nwr);
    end
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || (nrd + nwr) !== 0) begin
      n_fail++; $display("FAIL size_11: err=%b data=%h lat=%0d strobes=%0d want 1/0/1/0", err, rd, lat, nrd + nwr);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
`ifdef LSU_ALIGN_TRAP_EN
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || (nrd + nwr) !== 0) begin
      n_fail++; $display("FAIL lw_misaligned: err=%b data=%h lat=%0d strobes=%0d want 1/0/1/0", err, rd, lat, nrd + nwr);
    end
`else
    if (err !== 1'b0 || rd !== 32'hDEAABEEF || lat !== 2 || ma !== 32'h10) begin
      n_fail++; $display("FAIL lw_misaligned: err=%b data=%h lat=%0d addr=%h want 0/deaabeef/2/10", err, rd, lat, ma);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, wl, ma; logic err; int lat, nrd, nwr, wr_seen;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, err, lat, nrd, nwr, wl, ma);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_cmp++;
    if (bus.MemRead !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_rd: MemRead=%b want 1", bus.MemRead);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite} !== 5'b10000 ||
        {bus.addr, bus.WriteData, bus.resp_rdata} !== 96'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: ctrl=%b addr=%h wd=%h rdata=%h want 10000/0/0/0",
                         {bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite},
                         bus.addr, bus.WriteData, bus.resp_rdata);
    end
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.MemWrite) wr_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.MemWrite) wr_seen++;
    end
    n_cmp++;
    if (wr_seen !== 0 || mem[8] !== 32'h11223344) begin
      n_fail++; $display("FAIL rst_mid_mem: writes=%0d mem=%h want 0/11223344", wr_seen, mem[8]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, err, lat, nrd, nwr, wl, ma);
    n_cmp++;
    if (rd !== 32'h11223344 || lat !== 2) begin
      n_fail++; $display("FAIL rst_mid_after: data=%h lat=%0d want 11223344/2", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic        wev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  szv [4] = '{2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] adv [4] = '{32'h30, 32'h30, 32'h31, 32'h30};
    logic [31:0] wdv [4] = '{32'hCAFEF00D, 32'h0, 32'h77, 32'h0};
    logic [31:0] rsp [4];
    logic        rdy;
    int idx = 0, n_acc = 0, n_resp = 0, overlap = 0, busy_rdy = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = wev[0]; bus.req_size = szv[0];
    bus.req_unsigned = 1'b0; bus.req_addr = adv[0]; bus.req_wdata = wdv[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk); #1;
      if (rdy && bus.req_valid) begin
        n_acc++;
        idx++;
        if (idx < 4) begin
          bus.req_we = wev[idx]; bus.req_size = szv[idx];
          bus.req_addr = adv[idx]; bus.req_wdata = wdv[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (bus.resp_valid) begin
        if (n_resp < 4) rsp[n_resp] = bus.resp_rdata;
        n_resp++;
      end
      if (bus.MemRead && bus.MemWrite) overlap++;
      if (bus.req_ready && (bus.MemRead || bus.MemWrite || bus.resp_valid)) busy_rdy++;
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (n_acc !== 4 || n_resp !== 4) begin
      n_fail++; $display("FAIL b2b_count: accepts=%0d resps=%0d want 4/4", n_acc, n_resp);
    end
    n_cmp++;
    if (overlap !== 0 || busy_rdy !== 0) begin
      n_fail++; $display("FAIL b2b_strobes: overlap=%0d ready_while_busy=%0d want 0/0", overlap, busy_rdy);
    end
    n_cmp++;
    if (rsp[1] !== 32'hCAFEF00D || rsp[3] !== 32'hCAFE770D) begin
      n_fail++; $display("FAIL b2b_data: r1=%h r3=%h want cafef00d/cafe770d", rsp[1], rsp[3]);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_word_store_load();
    test_subword_store();
    test_load_extend();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
